ifetch_ctrl: RTL

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/sisc_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 76 +++++++
 rtl/ifetch_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared widths, reset fetch address and fetch FSM encoding for the fetch stage.
package sisc_pkg;

   localparam int ADDR_W     = 16;
   localparam int INSTR_W    = 32;
   localparam int ENTRY_W    = ADDR_W + INSTR_W;
   localparam int FIFO_DEPTH = 2;

   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // A buffer entry carries the word address in the upper bits and the instruction below it.
   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] pc,
                                                     input logic [INSTR_W-1:0] word);
      return {pc, word};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, instruction} entries.
// Storage is plain flops so the head is visible in the cycle after a push.
module ifetch_fifo
   import sisc_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] w_entries [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] r_data;

         // Capture incoming data when this slot is the write target.
         always_ff @(posedge clk) begin
            if (w_do_push && (r_wr_ptr == PTR_W'(gi))) begin
               r_data <= din;
            end
         end

         assign w_entries[gi] = r_data;
      end
   endgenerate

   // Pointer and occupancy bookkeeping; clear behaves like a reset of the bookkeeping only.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = w_entries[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc through instruction memory,
// buffers fetched words in a 2-entry prefetch FIFO, and handles redirects and halt.
module ifetch_ctrl
   import sisc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = sisc_pkg::RESET_PC,
   parameter int                DEPTH    = FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  im_addr,
   input  logic [INSTR_W-1:0] im_data,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   input  logic               halt,
   output logic               halted
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t       r_state;
   fetch_state_t       w_state_next;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  w_fetch_pc_next;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic [ENTRY_W-1:0] w_head;
   logic [ENTRY_W-1:0] w_push_entry;

   // Memory answers in the same cycle, so the address comes straight off the register.
   assign im_addr      = r_fetch_pc;
   assign w_pop        = instr_valid && instr_ready;
   assign w_push_entry = pack_entry(r_fetch_pc, im_data);

   // Fetch FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state follows the halt level; a redirect overrides any push and reloads the fetch address.
   always_comb begin
      w_state_next    = r_state;
      w_push          = 1'b0;
      w_fetch_pc_next = r_fetch_pc;

      case (r_state)
         ST_RUN:  if (halt)  w_state_next = ST_HALT;
         ST_HALT: if (!halt) w_state_next = ST_RUN;
         default: w_state_next = ST_RUN;
      endcase

      if (br_taken) begin
         w_fetch_pc_next = br_target;
      end else if ((r_state == ST_RUN) && (!w_full || w_pop)) begin
         w_push          = 1'b1;
         w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);   // wraps FFFF -> 0000 silently
      end
   end

   // Fetch address register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else begin
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   // A head popped in the redirect cycle is simply lost in the clear, which is the intended behaviour.
   ifetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .clear (br_taken),
      .din   (w_push_entry),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Outputs depend only on flops, never on this cycle's inputs.
   assign instr_valid = (w_count != '0);
   assign instr       = w_empty ? '0 : w_head[INSTR_W-1:0];
   assign instr_pc    = w_empty ? '0 : w_head[ENTRY_W-1:INSTR_W];
   assign halted      = (r_state == ST_HALT);

endmodule
